store_alignment: RTL and testbench

//  Store-path counterpart of the load aligner: takes an rv32 store (SB/SH/SW), lane-shifts the data

---
 rtl/store_alignment.sv | 258 +++++++++++++++++++++++++
 tb/tb_store_alignment.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_alignment.sv
// Store aligner: lane-shifts SB/SH/SW data into a word-aligned write beat with byte strobes.
// Optional macro STORE_SPLIT_MISALIGNED_EN: word-crossing SH/SW become two beats instead of being rejected.

`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif
`ifndef STORE_OP_SB
`define STORE_OP_SB 2'd0
`endif
`ifndef STORE_OP_SH
`define STORE_OP_SH 2'd1
`endif
`ifndef STORE_OP_SW
`define STORE_OP_SW 2'd2
`endif

module store_alignment (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic [`STORE_OP_WIDTH-1:0] req_op,
  input  logic [31:0]                req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic                       done,
  output logic                       misaligned_err
);

`ifdef STORE_SPLIT_MISALIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_RESP  = 2'd3
  } state_t;
`endif

  state_t      state_r;
  state_t      state_s;

  logic        req_ready_r;
  logic        req_ready_s;
  logic        mem_valid_r;
  logic        mem_valid_s;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_r;
  logic [31:0] mem_wdata_s;
  logic [3:0]  mem_wstrb_r;
  logic [3:0]  mem_wstrb_s;
  logic        done_r;
  logic        done_s;
  logic        err_r;
  logic        err_s;

  logic        accept_s;
  logic [1:0]  lane_k_s;
  logic        op_known_s;
  logic [31:0] base_data_s;
  logic [3:0]  base_strb_s;
  logic [7:0]  strb_wide_s;
  logic        crosses_s;
  logic        reject_s;
  logic [31:0] beat0_wdata_s;

  // Operand width: low-lane data and strobe pattern before the lane shift.
  always_comb begin
    op_known_s  = 1'b1;
    base_data_s = 32'h0000_0000;
    base_strb_s = 4'b0000;
    case (req_op)
      `STORE_OP_SB: begin
        base_data_s = {24'h00_0000, req_data[7:0]};
        base_strb_s = 4'b0001;
      end
      `STORE_OP_SH: begin
        base_data_s = {16'h0000, req_data[15:0]};
        base_strb_s = 4'b0011;
      end
      `STORE_OP_SW: begin
        base_data_s = req_data;
        base_strb_s = 4'b1111;
      end
      default: begin
        op_known_s  = 1'b0;
        base_data_s = 32'h0000_0000;
        base_strb_s = 4'b0000;
      end
    endcase
  end

  // Strobes shifted into an 8-lane window: the upper nibble is what spills into the next word.
  assign lane_k_s    = req_addr[1:0];
  assign strb_wide_s = {4'b0000, base_strb_s} << lane_k_s;
  assign crosses_s   = |strb_wide_s[7:4];
  assign accept_s    = req_valid & req_ready_r;

`ifdef STORE_SPLIT_MISALIGNED_EN
  logic [63:0] data_wide_s;
  logic        split_r;
  logic [31:0] beat1_wdata_r;
  logic [3:0]  beat1_strb_r;

  assign data_wide_s   = {32'h0000_0000, base_data_s} << {lane_k_s, 3'b000};
  assign beat0_wdata_s = data_wide_s[31:0];
  assign reject_s      = ~op_known_s;
`else
  assign beat0_wdata_s = base_data_s << {lane_k_s, 3'b000};
  assign reject_s      = ~op_known_s | crosses_s;
`endif

  // Next-state sequencing of the write transaction.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (reject_s) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_BEAT0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
`ifdef STORE_SPLIT_MISALIGNED_EN
          if (split_r) begin
            state_s = ST_BEAT1;
          end else begin
            state_s = ST_RESP;
          end
`else
          state_s = ST_RESP;
`endif
        end else begin
          state_s = ST_BEAT0;
        end
      end
`ifdef STORE_SPLIT_MISALIGNED_EN
      ST_BEAT1: begin
        if (mem_ready) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_BEAT1;
        end
      end
`endif
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    req_ready_s = (state_s == ST_IDLE);
`ifdef STORE_SPLIT_MISALIGNED_EN
    mem_valid_s = (state_s == ST_BEAT0) | (state_s == ST_BEAT1);
`else
    mem_valid_s = (state_s == ST_BEAT0);
`endif
    done_s      = 1'b0;
    err_s       = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_wstrb_s = mem_wstrb_r;
    if (state_s == ST_RESP) begin
      // RESP straight from IDLE only happens for a rejected request.
      if (state_r == ST_IDLE) begin
        err_s = 1'b1;
      end else begin
        done_s = 1'b1;
      end
      mem_wdata_s = 32'h0000_0000;
      mem_wstrb_s = 4'b0000;
    end else if ((state_r == ST_IDLE) && (state_s == ST_BEAT0)) begin
      mem_addr_s  = {req_addr[31:2], 2'b00};
      mem_wdata_s = beat0_wdata_s;
      mem_wstrb_s = strb_wide_s[3:0];
    end
`ifdef STORE_SPLIT_MISALIGNED_EN
    else if ((state_r == ST_BEAT0) && (state_s == ST_BEAT1)) begin
      mem_addr_s  = mem_addr_r + 32'd4;
      mem_wdata_s = beat1_wdata_r;
      mem_wstrb_s = beat1_strb_r;
    end
`endif
    else begin
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      mem_wstrb_s = mem_wstrb_r;
    end
  end

  // State and output registers; reset drops any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wstrb_r <= 4'b0000;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      mem_valid_r <= mem_valid_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_wstrb_r <= mem_wstrb_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

`ifdef STORE_SPLIT_MISALIGNED_EN
  // Second-beat lanes captured at accept so the beat0->beat1 step is a plain register move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_r       <= 1'b0;
      beat1_wdata_r <= 32'h0000_0000;
      beat1_strb_r  <= 4'b0000;
    end else if (accept_s) begin
      split_r       <= crosses_s;
      beat1_wdata_r <= data_wide_s[63:32];
      beat1_strb_r  <= strb_wide_s[7:4];
    end
  end
`endif

  assign req_ready      = req_ready_r;
  assign mem_valid      = mem_valid_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wdata      = mem_wdata_r;
  assign mem_wstrb      = mem_wstrb_r;
  assign done           = done_r;
  assign misaligned_err = err_r;

endmodule

// File: tb/tb_store_alignment.sv
// Randomized bench for store_alignment: a byte-level model predicts the beat/done/err sequence per store.
// Honours STORE_SPLIT_MISALIGNED_EN the same way the design does.

`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif
`ifndef STORE_OP_SB
`define STORE_OP_SB 2'd0
`endif
`ifndef STORE_OP_SH
`define STORE_OP_SH 2'd1
`endif
`ifndef STORE_OP_SW
`define STORE_OP_SW 2'd2
`endif

module tb_store_alignment;

  logic                       clk;
  logic                       rst;
  logic                       req_valid;
  logic                       req_ready;
  logic [31:0]                req_addr;
  logic [`STORE_OP_WIDTH-1:0] req_op;
  logic [31:0]                req_data;
  logic                       mem_valid;
  logic                       mem_ready;
  logic [31:0]                mem_addr;
  logic [31:0]                mem_wdata;
  logic [3:0]                 mem_wstrb;
  logic                       done;
  logic                       misaligned_err;

  store_alignment dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_op         (req_op),
    .req_data       (req_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .done           (done),
    .misaligned_err (misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STORE_SPLIT_MISALIGNED_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam logic [1:0] EV_BEAT = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } ev_t;

  ev_t exp_q[$];
  ev_t mdl_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  mon_sz;
  ev_t mon_ev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: walk the store byte by byte, group bytes by word address into beats.
  task automatic build(input logic [31:0] a, input logic [`STORE_OP_WIDTH-1:0] op, input logic [31:0] d);
    int          nb;
    int          lane;
    logic [31:0] ba;
    logic [31:0] w;
    ev_t         ev;
    mdl_q.delete();
    if (op == `STORE_OP_SB) nb = 1;
    else if (op == `STORE_OP_SH) nb = 2;
    else if (op == `STORE_OP_SW) nb = 4;
    else nb = 0;
    if ((nb == 0) || (((int'(a[1:0]) + nb) > 4) && !SPLIT)) begin
      ev = '0;
      ev.kind = EV_ERR;
      mdl_q.push_back(ev);
    end else begin
      for (int i = 0; i < nb; i++) begin
        ba   = a + 32'(i);
        w    = {ba[31:2], 2'b00};
        lane = int'(ba[1:0]);
        if ((mdl_q.size() == 0) || (mdl_q[mdl_q.size()-1].addr != w)) begin
          ev = '0;
          ev.kind = EV_BEAT;
          ev.addr = w;
          mdl_q.push_back(ev);
        end
        ev = mdl_q[mdl_q.size()-1];
        ev.wdata[lane*8 +: 8] = d[i*8 +: 8];
        ev.strb[lane] = 1'b1;
        mdl_q[mdl_q.size()-1] = ev;
      end
      ev = '0;
      ev.kind = EV_DONE;
      mdl_q.push_back(ev);
    end
  endtask

  task automatic pin_beat(input string nm, input int idx, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st);
    check({nm, "_kind"}, 32'(mdl_q[idx].kind), 32'(EV_BEAT));
    check({nm, "_addr"}, mdl_q[idx].addr, a);
    check({nm, "_wdata"}, mdl_q[idx].wdata, wd);
    check({nm, "_strb"}, 32'(mdl_q[idx].strb), 32'(st));
  endtask

  // Compare process: whatever event heads the expectation queue must be on the outputs now.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      mon_sz = exp_q.size();
      check("req_ready", 32'(req_ready), 32'(mon_sz == 0));
      if (mon_sz == 0) begin
        check("idle_quiet", 32'({mem_valid, done, misaligned_err}), 32'h0);
      end else begin
        mon_ev = exp_q[0];
        if (mon_ev.kind == EV_BEAT) begin
          check("beat_flags", 32'({mem_valid, done, misaligned_err}), 32'h4);
          check("beat_addr", mem_addr, mon_ev.addr);
          check("beat_wdata", mem_wdata, mon_ev.wdata);
          check("beat_strb", 32'(mem_wstrb), 32'(mon_ev.strb));
          if (mem_valid && mem_ready) void'(exp_q.pop_front());
        end else if (mon_ev.kind == EV_DONE) begin
          check("done_pulse", 32'({mem_valid, done, misaligned_err}), 32'h2);
          void'(exp_q.pop_front());
        end else begin
          check("err_pulse", 32'({mem_valid, done, misaligned_err}), 32'h1);
          void'(exp_q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        build(req_addr, req_op, req_data);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one store and keep poking mem_ready / junk requests until done or err shows.
  task automatic do_store(input logic [31:0] a, input logic [`STORE_OP_WIDTH-1:0] op,
                          input logic [31:0] d, input int stall, input bit rnd_rdy,
                          output int vcyc, output bit saw_done, output bit saw_err);
    int guard;
    bit fin;
    guard = 0;
    while (!req_ready && (guard < 20)) begin
      tick();
      guard++;
    end
    check("ready_wait", 32'(req_ready), 32'h1);
    req_valid = 1'b1;
    req_addr  = a;
    req_op    = op;
    req_data  = d;
    mem_ready = 1'($urandom_range(0, 1));
    tick();
    req_valid = 1'b0;
    vcyc = 0;
    saw_done = 1'b0;
    saw_err = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; (cyc < 60) && !fin; cyc++) begin
      if (mem_valid) vcyc++;
      if (done || misaligned_err) begin
        saw_done  = done;
        saw_err   = misaligned_err;
        fin       = 1'b1;
        req_valid = 1'b0;
      end else begin
        if (cyc < stall) mem_ready = 1'b0;
        else if (rnd_rdy) mem_ready = 1'($urandom_range(0, 1));
        else mem_ready = 1'b1;
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_op    = `STORE_OP_WIDTH'($urandom_range(0, 3));
        req_data  = $urandom;
        tick();
      end
    end
    check("store_finish", 32'(fin), 32'h1);
  endtask

  int          vc;
  bit          sd;
  bit          se;
  logic [31:0] ra;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_op    = `STORE_OP_SB;
    req_data  = 32'h0;
    mem_ready = 1'b0;

    // Hand-computed expectations pinning the model.
    build(32'h0000_0103, `STORE_OP_SB, 32'hAABB_CC5A);
    check("pin_sb_n", 32'(mdl_q.size()), 32'd2);
    pin_beat("pin_sb", 0, 32'h0000_0100, 32'h5A00_0000, 4'b1000);
    check("pin_sb_done", 32'(mdl_q[1].kind), 32'(EV_DONE));
    build(32'h0000_0301, `STORE_OP_SH, 32'h0000_1234);
    pin_beat("pin_sh1", 0, 32'h0000_0300, 32'h0012_3400, 4'b0110);
`ifdef STORE_SPLIT_MISALIGNED_EN
    build(32'h0000_0303, `STORE_OP_SH, 32'h0000_BEEF);
    check("pin_sh3_n", 32'(mdl_q.size()), 32'd3);
    pin_beat("pin_sh3_b0", 0, 32'h0000_0300, 32'hEF00_0000, 4'b1000);
    pin_beat("pin_sh3_b1", 1, 32'h0000_0304, 32'h0000_00BE, 4'b0001);
    build(32'hFFFF_FFFE, `STORE_OP_SW, 32'h1122_3344);
    pin_beat("pin_swtop_b0", 0, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
    pin_beat("pin_swtop_b1", 1, 32'h0000_0000, 32'h0000_1122, 4'b0011);
`else
    build(32'h0000_0201, `STORE_OP_SW, 32'h1122_3344);
    check("pin_sw201_n", 32'(mdl_q.size()), 32'd1);
    check("pin_sw201_err", 32'(mdl_q[0].kind), 32'(EV_ERR));
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", 32'({req_ready, mem_valid, done, misaligned_err}), 32'h8);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_strb", 32'(mem_wstrb), 32'h0);
    rst = 1'b0;
    tick();

    do_store(32'h0000_0103, `STORE_OP_SB, 32'hAABB_CC5A, 0, 1'b1, vc, sd, se);
    check("sb103_done", 32'({sd, se}), 32'h2);
    do_store(32'h0000_0200, `STORE_OP_SW, 32'h1234_5678, 3, 1'b0, vc, sd, se);
    check("sw200_stall_cycles", 32'(vc), 32'd4);
    check("sw200_done", 32'({sd, se}), 32'h2);
    do_store(32'h0000_0303, `STORE_OP_SH, 32'h0000_BEEF, 1, 1'b1, vc, sd, se);
    do_store(32'hFFFF_FFFE, `STORE_OP_SW, 32'h1122_3344, 0, 1'b1, vc, sd, se);
    do_store(32'h0000_0201, `STORE_OP_SW, 32'h1122_3344, 0, 1'b1, vc, sd, se);
`ifdef STORE_SPLIT_MISALIGNED_EN
    check("sw201_split_cycles", 32'(vc >= 2), 32'h1);
    check("sw201_done", 32'({sd, se}), 32'h2);
`else
    check("sw201_novalid", 32'(vc), 32'd0);
    check("sw201_err", 32'({sd, se}), 32'h1);
    tick();
    check("sw201_ready_back", 32'(req_ready), 32'h1);
`endif

    // Reset while BEAT0 is stalled on mem_ready.
    while (!req_ready) tick();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0400;
    req_op    = `STORE_OP_SW;
    req_data  = 32'hCAFE_F00D;
    mem_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_valid", 32'(mem_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_flags", 32'({req_ready, mem_valid, done, misaligned_err}), 32'h8);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      tick();
    end

    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      if ((n % 16) == 0) ra[31:2] = 30'h3FFF_FFFF;
      do_store(ra, `STORE_OP_WIDTH'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 3), 1'b1, vc, sd, se);
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
